// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port (IF read / MEM read-write) arbiter onto one narrow external RAM
// Each requester word is moved as BEATS little-endian RAM beats with programmable wait states.
module mem_port_arbiter #(
  parameter int DATA_W      = 32,
  parameter int RAM_W       = 16,
  parameter int ADDR_W      = 18,
  parameter int WAIT_STATES = 0,
  parameter int ARB_MODE    = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ack,
  output logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic              ram_oe,
  output logic [RAM_W-1:0]  ram_wdata,
  input  logic [RAM_W-1:0]  ram_rdata,
  output logic              busy
);

  localparam int BEATS = DATA_W / RAM_W;
  localparam int BW    = $clog2(BEATS);
  localparam int CW    = (BW > 0) ? BW : 1;
  localparam logic [ADDR_W-1:0] LOW_MASK  = ADDR_W'(BEATS - 1);
  localparam logic [CW-1:0]     LAST_BEAT = CW'(BEATS - 1);
  localparam logic [3:0]        WCNT_END  = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t            state_q, state_d;
  logic              grant_mem_q, grant_mem_d;
  logic              pref_mem_q, pref_mem_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CW-1:0]     beat_q, beat_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              pick_mem;
  logic              xfer;

  // MEM wins unless IF is also asking and round-robin currently favours IF
  assign pick_mem = mem_req && (!if_req || (ARB_MODE == 0) || pref_mem_q);

  always_comb begin
    state_d     = state_q;
    grant_mem_d = grant_mem_q;
    pref_mem_d  = pref_mem_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    beat_d      = beat_q;
    wcnt_d      = wcnt_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    case (state_q)
      IDLE: begin
        if (if_req || mem_req) begin
          grant_mem_d = pick_mem;
          pref_mem_d  = !pick_mem;
          we_d        = pick_mem && mem_we;
          addr_d      = (pick_mem ? mem_addr : if_addr) & ~LOW_MASK;
          wdata_d     = pick_mem ? mem_wdata : '0;
          beat_d      = '0;
          wcnt_d      = '0;
          state_d     = XFER;
        end
      end
      XFER: begin
        if (wcnt_q == WCNT_END) begin
          wcnt_d = '0;
          beat_d = beat_q + CW'(1);
          if (!we_q) begin
            if (grant_mem_q) mem_rdata_d[int'(beat_q)*RAM_W +: RAM_W] = ram_rdata;
            else             if_rdata_d[int'(beat_q)*RAM_W +: RAM_W]  = ram_rdata;
          end
          if (beat_q == LAST_BEAT) state_d = DONE;
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      grant_mem_q <= 1'b0;
      pref_mem_q  <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      beat_q      <= '0;
      wcnt_q      <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_mem_q <= grant_mem_d;
      pref_mem_q  <= pref_mem_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      beat_q      <= beat_d;
      wcnt_q      <= wcnt_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // Pad outputs decode straight from state so an async reset drops them at once
  assign xfer      = (state_q == XFER);
  assign busy      = (state_q != IDLE);
  assign ram_we    = xfer && we_q;
  assign ram_oe    = xfer && we_q;
  assign ram_addr  = xfer ? (addr_q | {{(ADDR_W-CW){1'b0}}, beat_q}) : '0;
  assign ram_wdata = xfer ? wdata_q[int'(beat_q)*RAM_W +: RAM_W] : '0;
  assign if_ack    = (state_q == DONE) && !grant_mem_q;
  assign mem_ack   = (state_q == DONE) && grant_mem_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;

endmodule
